// File: rtl/mii_nibble_tx_pkg.sv
// Shared definitions for the MII nibble transmitter: FSM encoding, idle nibble
// and the default inter-frame gap shared with the MAC TX path.
package mii_nibble_tx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_DROP   = 2'd2,
      ST_IFG    = 2'd3
   } state_t;

   localparam logic [3:0] MII_IDLE_NIBBLE     = 4'h0;
   localparam int         DEFAULT_IFG_NIBBLES = 24;

endpackage

// File: rtl/mii_nibble_tx_if.sv
// Byte stream from the MAC TX path into the MII nibble transmitter.
interface mii_nibble_tx_if;

   logic [7:0] in_data;
   logic       in_valid;
   logic       in_last;
   logic       in_er;
   logic       in_ready;

   modport master (
      output in_data, in_valid, in_last, in_er,
      input  in_ready
   );

   modport slave (
      input  in_data, in_valid, in_last, in_er,
      output in_ready
   );

endinterface

// File: rtl/mii_nibble_tx_ssio_sdr_out.sv
// Generic SDR output register intended to pack into the I/O block; the
// attribute used depends on the target vendor.
module ssio_sdr_out #(
   parameter string TARGET = "GENERIC",
   parameter int    WIDTH  = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   generate
      if (TARGET == "XILINX") begin : g_xilinx
         (* IOB = "TRUE" *) logic [WIDTH-1:0] q_reg;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) q_reg <= '0;
            else        q_reg <= d;
         end
         assign q = q_reg;
      end else if (TARGET == "ALTERA") begin : g_altera
         (* useioff = 1 *) logic [WIDTH-1:0] q_reg;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) q_reg <= '0;
            else        q_reg <= d;
         end
         assign q = q_reg;
      end else begin : g_generic
         logic [WIDTH-1:0] q_reg;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) q_reg <= '0;
            else        q_reg <= d;
         end
         assign q = q_reg;
      end
   endgenerate

endmodule

// File: rtl/mii_nibble_tx.sv
// MII transmit serializer: bytes in over a valid/ready handshake, two nibbles
// out (low first) through IOB output registers, with IFG and underrun abort.
module mii_nibble_tx
   import mii_nibble_tx_pkg::*;
#(
   parameter string TARGET      = "GENERIC",
   parameter int    IFG_NIBBLES = DEFAULT_IFG_NIBBLES,
   parameter int    CNT_WIDTH   = 5
) (
   input  logic                 clk,
   input  logic                 rst_n,
   mii_nibble_tx_if.slave       bus,
   output logic [3:0]           mii_txd,
   output logic                 mii_tx_en,
   output logic                 mii_tx_er,
   output logic                 frame_done,
   output logic                 underrun
);

   localparam logic [CNT_WIDTH-1:0] IFG_LOAD = CNT_WIDTH'(IFG_NIBBLES);

   state_t               state_reg;
   logic                 phase_reg;
   logic [CNT_WIDTH-1:0] cnt_reg;
   logic                 ready_reg;
   logic [3:0]           hi_nibble_reg;
   logic                 last_reg;
   logic                 er_reg;
   logic                 frame_done_reg;
   logic                 underrun_reg;

   logic                 accept;
   logic [5:0]           out_next;
   logic [5:0]           out_q;

   assign accept       = bus.in_valid & ready_reg;
   assign bus.in_ready = ready_reg;
   assign frame_done   = frame_done_reg;
   assign underrun     = underrun_reg;

   // Output next-values {tx_er, tx_en, txd}; the pad register stage adds the cycle.
   always_comb begin
      out_next = {1'b0, 1'b0, MII_IDLE_NIBBLE};
      if (state_reg == ST_ACTIVE && phase_reg) begin
         out_next = {er_reg, 1'b1, hi_nibble_reg};
      end else if ((state_reg == ST_IDLE || state_reg == ST_ACTIVE) && accept) begin
         out_next = {bus.in_er, 1'b1, bus.in_data[3:0]};
      end else if (state_reg == ST_ACTIVE) begin
         out_next = {1'b1, 1'b1, MII_IDLE_NIBBLE};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= ST_IDLE;
         phase_reg      <= 1'b0;
         cnt_reg        <= '0;
         ready_reg      <= 1'b0;
         hi_nibble_reg  <= 4'h0;
         last_reg       <= 1'b0;
         er_reg         <= 1'b0;
         frame_done_reg <= 1'b0;
         underrun_reg   <= 1'b0;
      end else begin
         frame_done_reg <= 1'b0;
         underrun_reg   <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               ready_reg <= 1'b1;
               if (accept) begin
                  state_reg     <= ST_ACTIVE;
                  phase_reg     <= 1'b1;
                  ready_reg     <= 1'b0;
                  hi_nibble_reg <= bus.in_data[7:4];
                  last_reg      <= bus.in_last;
                  er_reg        <= bus.in_er;
               end
            end
            ST_ACTIVE: begin
               if (phase_reg) begin
                  phase_reg <= 1'b0;
                  if (last_reg) begin
                     frame_done_reg <= 1'b1;
                     state_reg      <= ST_IFG;
                     cnt_reg        <= IFG_LOAD;
                     ready_reg      <= 1'b0;
                  end else begin
                     ready_reg <= 1'b1;
                  end
               end else if (accept) begin
                  phase_reg     <= 1'b1;
                  ready_reg     <= 1'b0;
                  hi_nibble_reg <= bus.in_data[7:4];
                  last_reg      <= bus.in_last;
                  er_reg        <= bus.in_er;
               end else begin
                  underrun_reg <= 1'b1;
                  state_reg    <= ST_DROP;
                  ready_reg    <= 1'b1;
               end
            end
            ST_DROP: begin
               if (accept && bus.in_last) begin
                  state_reg <= ST_IFG;
                  cnt_reg   <= IFG_LOAD;
                  ready_reg <= 1'b0;
               end
            end
            ST_IFG: begin
               // Ready rises one edge early so the next low nibble lands right after the gap.
               if (cnt_reg <= CNT_WIDTH'(1)) begin
                  state_reg <= ST_IDLE;
                  ready_reg <= 1'b1;
               end else begin
                  cnt_reg <= cnt_reg - CNT_WIDTH'(1);
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   ssio_sdr_out #(
      .TARGET (TARGET),
      .WIDTH  (6)
   ) u_out (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (out_next),
      .q     (out_q)
   );

   assign {mii_tx_er, mii_tx_en, mii_txd} = out_q;

endmodule

// File: tb/tb_mii_nibble_tx.sv
// Cycle table of handshake inputs and expected MII outputs, plus a hand-written
// mid-frame reset sequence.
module tb_mii_nibble_tx;

   localparam int IFG = 24;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] mii_txd;
   logic       mii_tx_en;
   logic       mii_tx_er;
   logic       frame_done;
   logic       underrun;

   mii_nibble_tx_if bus();

   mii_nibble_tx #(
      .TARGET      ("SIM"),
      .IFG_NIBBLES (IFG),
      .CNT_WIDTH   (5)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .mii_txd    (mii_txd),
      .mii_tx_en  (mii_tx_en),
      .mii_tx_er  (mii_tx_er),
      .frame_done (frame_done),
      .underrun   (underrun)
   );

   always #5 clk = ~clk;

   // exp = {in_ready, frame_done, underrun, tx_er, tx_en, txd}
   typedef struct {
      logic       valid;
      logic [7:0] data;
      logic       last;
      logic       er;
      logic [8:0] exp;
      int         tid;
   } vec_t;

   vec_t vecs[$];
   int   tests   = 0;
   int   fails   = 0;
   int   cur_tid = 0;

   task automatic add(input logic v, input logic [7:0] d, input logic l, input logic e,
                      input logic r, input logic fd, input logic ur, input logic er,
                      input logic en, input logic [3:0] txd);
      vec_t x;
      x.valid = v;
      x.data  = d;
      x.last  = l;
      x.er    = e;
      x.exp   = {r, fd, ur, er, en, txd};
      x.tid   = cur_tid;
      vecs.push_back(x);
   endtask

   task automatic add_idle_gap();
      for (int k = 1; k <= IFG; k++) add(1'b0, 8'h00, 1'b0, 1'b0, k == IFG, 0, 0, 0, 0, 4'h0);
   endtask

   task automatic drive(input logic v, input logic [7:0] d, input logic l, input logic e);
      bus.in_valid = v;
      bus.in_data  = d;
      bus.in_last  = l;
      bus.in_er    = e;
   endtask

   task automatic check(input int tid, input int step, input logic [8:0] want);
      logic [8:0] got;
      got = {bus.in_ready, frame_done, underrun, mii_tx_er, mii_tx_en, mii_txd};
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL t%0d step %0d {rdy,fd,ur,er,en,txd} got %b want %b", tid, step, got, want);
      end
   endtask

   task automatic build();
      // t1: 3-byte frame; junk data offered while ready is low must not be taken
      cur_tid = 1;
      add(1, 8'hA5, 0, 0, 1, 0, 0, 0, 0, 4'h0);
      add(1, 8'hA5, 0, 0, 0, 0, 0, 0, 1, 4'h5);
      add(1, 8'h99, 0, 0, 1, 0, 0, 0, 1, 4'hA);
      add(1, 8'h3C, 0, 0, 0, 0, 0, 0, 1, 4'hC);
      add(1, 8'h5B, 1, 0, 1, 0, 0, 0, 1, 4'h3);
      add(1, 8'h7E, 1, 0, 0, 0, 0, 0, 1, 4'hE);
      add(0, 8'h00, 0, 0, 0, 1, 0, 0, 1, 4'h7);
      // t6: valid held high with changing data throughout the gap
      cur_tid = 6;
      for (int k = 1; k <= IFG; k++)
         add(1, 8'h80 | 8'(k), k[0], 0, k == IFG, 0, 0, 0, 0, 4'h0);
      // t2: back-to-back single-byte frames
      cur_tid = 2;
      add(1, 8'h12, 1, 0, 0, 0, 0, 0, 1, 4'h2);
      add(1, 8'h34, 1, 0, 0, 1, 0, 0, 1, 4'h1);
      for (int k = 1; k <= IFG; k++) add(1, 8'h34, 1, 0, k == IFG, 0, 0, 0, 0, 4'h0);
      add(1, 8'h34, 1, 0, 0, 0, 0, 0, 1, 4'h4);
      add(0, 8'h00, 0, 0, 0, 1, 0, 0, 1, 4'h3);
      add_idle_gap();
      // t3: underrun after byte 2, remaining bytes dropped
      cur_tid = 3;
      add(1, 8'h11, 0, 0, 0, 0, 0, 0, 1, 4'h1);
      add(1, 8'h22, 0, 0, 1, 0, 0, 0, 1, 4'h1);
      add(1, 8'h22, 0, 0, 0, 0, 0, 0, 1, 4'h2);
      add(0, 8'h00, 0, 0, 1, 0, 0, 0, 1, 4'h2);
      add(0, 8'h00, 0, 0, 1, 0, 1, 1, 1, 4'h0);
      add(1, 8'h33, 0, 0, 1, 0, 0, 0, 0, 4'h0);
      add(1, 8'h44, 1, 0, 0, 0, 0, 0, 0, 4'h0);
      add_idle_gap();
      // t4: errored byte mid-frame
      cur_tid = 4;
      add(1, 8'h01, 0, 0, 0, 0, 0, 0, 1, 4'h1);
      add(1, 8'hFF, 0, 1, 1, 0, 0, 0, 1, 4'h0);
      add(1, 8'hFF, 0, 1, 0, 0, 0, 1, 1, 4'hF);
      add(1, 8'h02, 1, 0, 1, 0, 0, 1, 1, 4'hF);
      add(1, 8'h02, 1, 0, 0, 0, 0, 0, 1, 4'h2);
      add(0, 8'h00, 0, 0, 0, 1, 0, 0, 1, 4'h0);
      add_idle_gap();
      // t7: error together with last still completes the frame
      cur_tid = 7;
      add(1, 8'hC7, 1, 1, 0, 0, 0, 1, 1, 4'h7);
      add(0, 8'h00, 0, 0, 0, 1, 0, 1, 1, 4'hC);
      add_idle_gap();
   endtask

   initial begin
      rst_n = 1'b0;
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      build();
      repeat (3) @(negedge clk);
      check(0, 0, 9'b0);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         drive(vecs[i].valid, vecs[i].data, vecs[i].last, vecs[i].er);
         @(posedge clk);
         @(negedge clk);
         check(vecs[i].tid, i, vecs[i].exp);
      end

      // t5: reset during the high nibble of byte 2, then a fresh frame
      drive(1, 8'h55, 0, 0);
      @(posedge clk); @(negedge clk); check(5, 0, {1'b0, 4'b0001, 4'h5});
      drive(1, 8'h66, 0, 0);
      @(posedge clk); @(negedge clk); check(5, 1, {1'b1, 4'b0001, 4'h5});
      @(posedge clk); @(negedge clk); check(5, 2, {1'b0, 4'b0001, 4'h6});
      drive(0, 8'h00, 0, 0);
      @(posedge clk); @(negedge clk); check(5, 3, {1'b1, 4'b0001, 4'h6});
      rst_n = 1'b0;
      #1 check(5, 4, 9'b0);
      @(posedge clk); @(negedge clk); check(5, 5, 9'b0);
      rst_n = 1'b1;
      drive(1, 8'h9A, 1, 0);
      @(posedge clk); @(negedge clk); check(5, 6, {1'b1, 4'b0000, 4'h0});
      @(posedge clk); @(negedge clk); check(5, 7, {1'b0, 4'b0001, 4'hA});
      drive(0, 8'h00, 0, 0);
      @(posedge clk); @(negedge clk); check(5, 8, {1'b0, 4'b1001, 4'h9});
      @(posedge clk); @(negedge clk); check(5, 9, 9'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
